ws2812_frame_cfg: RTL

- Parametrised per-pixel colour source for a chain of WS2812 8x8 panels.
- Selects a glyph from a small ROM, paints foreground pixels with the live RGB input and the rest with a fixed background colour, and applies a key-adjustable brightness shift.
- Paces frames by issuing the frame start to the downstream ws2812 driver and advancing a pixel index on each driver request.
- Settings are latched at frame boundaries, so a frame never mixes old and new settings.

---
 rtl/ws2812_pkg.sv | 24 ++
 rtl/ws2812_glyph_rom.sv | 46 ++++
 rtl/ws2812_frame_cfg.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812 frame colour source:
// FSM states, glyph codes and the per-channel colour width.
package ws2812_pkg;

    localparam int CH_W = 8;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_START = 2'd1,
        S_FEED  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam logic [1:0] GLY_BLANK = 2'd0;
    localparam logic [1:0] GLY_S     = 2'd1;
    localparam logic [1:0] GLY_D     = 2'd2;

    // Brightness scaling is a plain logical right shift of one channel.
    function automatic logic [CH_W-1:0] ch_shift(input logic [CH_W-1:0] v,
                                                 input logic [2:0]      s);
        return v >> s;
    endfunction

endpackage

// File: rtl/ws2812_glyph_rom.sv
// 8x8 glyph bitmaps; rows top to bottom, pixel 0 at the top-left, MSB of a
// row byte is the leftmost column. Code 3 is unused and reads as blank.
module ws2812_glyph_rom
    import ws2812_pkg::*;
(
    input  logic [1:0] glyph,
    input  logic [5:0] pix,
    output logic       mask
);

    logic [7:0] row_bits;

    always_comb begin
        row_bits = 8'h00;
        case (glyph)
            GLY_S: begin
                case (pix[5:3])
                    3'd0: row_bits = 8'h7E;
                    3'd1: row_bits = 8'hC0;
                    3'd2: row_bits = 8'hC0;
                    3'd3: row_bits = 8'h7C;
                    3'd4: row_bits = 8'h06;
                    3'd5: row_bits = 8'h06;
                    3'd6: row_bits = 8'hFC;
                    3'd7: row_bits = 8'h00;
                endcase
            end
            GLY_D: begin
                case (pix[5:3])
                    3'd0: row_bits = 8'hF8;
                    3'd1: row_bits = 8'hCC;
                    3'd2: row_bits = 8'hC6;
                    3'd3: row_bits = 8'hC6;
                    3'd4: row_bits = 8'hC6;
                    3'd5: row_bits = 8'hCC;
                    3'd6: row_bits = 8'hF8;
                    3'd7: row_bits = 8'h00;
                endcase
            end
            default: row_bits = 8'h00;
        endcase
    end

    assign mask = row_bits[3'd7 - pix[2:0]];

endmodule

// File: rtl/ws2812_frame_cfg.sv
// Per-pixel colour source and frame pacer for chained WS2812 8x8 panels.
// Optional blink of foreground pixels every 16 frames with WS2812_BLINK_EN.
module ws2812_frame_cfg
    import ws2812_pkg::*;
#(
    parameter int          NUM_PIX   = 64,
    parameter int          IDX_W     = 6,
    parameter int          WAIT_CYC  = 1_000_000,
    parameter int          GAP_CYC   = 50_000,
    parameter logic [23:0] BG_GRB    = 24'h17_06_18,
    parameter int          SHIFT_RST = 3
`ifdef WS2812_BLINK_EN
    ,
    parameter bit          BLINK_ON  = 1'b1
`endif
)(
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             cfg_start,
    input  logic [4:0]       key,
    input  logic [7:0]       data_r,
    input  logic [7:0]       data_g,
    input  logic [7:0]       data_b,
    output logic             ws2812_start,
    output logic [IDX_W-1:0] cfg_num,
    output logic [23:0]      cfg_data,
    output logic             frame_done,
    output logic             busy
);

    localparam int CNT_MAX = (WAIT_CYC > GAP_CYC) ? WAIT_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] cfg_num_q;
    logic             start_q;
    logic             done_q;
    logic             busy_q;
    logic [1:0]       glyph_req_q, glyph_req_d, glyph_act_q;
    logic [2:0]       shift_req_q, shift_req_d, shift_act_q;

    // Keys only touch the request registers; the frame uses the _act copies.
    always_comb begin
        glyph_req_d = glyph_req_q;
        case (key[4:2])
            3'b001:  glyph_req_d = GLY_S;
            3'b010:  glyph_req_d = GLY_D;
            3'b100:  glyph_req_d = GLY_BLANK;
            default: glyph_req_d = glyph_req_q;
        endcase

        shift_req_d = shift_req_q;
        if (key[1] && !key[0] && shift_req_q != 3'd0) begin
            shift_req_d = shift_req_q - 3'd1;
        end else if (key[0] && !key[1] && shift_req_q != 3'd7) begin
            shift_req_d = shift_req_q + 3'd1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            glyph_req_q <= GLY_BLANK;
            shift_req_q <= 3'(SHIFT_RST);
        end else begin
            glyph_req_q <= glyph_req_d;
            shift_req_q <= shift_req_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q     <= S_WAIT;
            cnt_q       <= '0;
            cfg_num_q   <= '0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            glyph_act_q <= GLY_BLANK;
            shift_act_q <= 3'(SHIFT_RST);
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_WAIT: begin
                    if (cnt_q == CNT_W'(WAIT_CYC - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_START;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_START: begin
                    glyph_act_q <= glyph_req_q;
                    shift_act_q <= shift_req_q;
                    cfg_num_q   <= '0;
                    state_q     <= S_FEED;
                end
                S_FEED: begin
                    if (cfg_start) begin
                        if (cfg_num_q == IDX_W'(NUM_PIX - 1)) begin
                            cfg_num_q <= '0;
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            cnt_q     <= '0;
                            state_q   <= S_GAP;
                        end else begin
                            cfg_num_q <= cfg_num_q + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_START;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_WAIT;
            endcase
        end
    end

    assign ws2812_start = start_q;
    assign frame_done   = done_q;
    assign busy         = busy_q;
    assign cfg_num      = cfg_num_q;

    logic mask;
    logic fg_en;

    ws2812_glyph_rom u_rom (
        .glyph (glyph_act_q),
        .pix   (cfg_num_q[5:0]),
        .mask  (mask)
    );

`ifdef WS2812_BLINK_EN
    logic [3:0] blink_cnt_q;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            blink_cnt_q <= 4'd0;
        end else if (done_q) begin
            blink_cnt_q <= blink_cnt_q + 4'd1;
        end
    end

    assign fg_en = mask && !(BLINK_ON && blink_cnt_q[3]);
`else
    assign fg_en = mask;
`endif

    logic [23:0] raw_grb;
    assign raw_grb = fg_en ? {data_g, data_r, data_b} : BG_GRB;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ch
            assign cfg_data[gi*CH_W +: CH_W] = ch_shift(raw_grb[gi*CH_W +: CH_W], shift_act_q);
        end
    endgenerate

endmodule
